// File: rtl/oddr_serdes_pkg.sv
// rtl/oddr_serdes_pkg.sv - shared constants, cell kind and sizing helpers for oddr_serdes
package oddr_serdes_pkg;

    localparam int LANES_MIN = 1;
    localparam int LANES_MAX = 16;
    localparam int RATIO_MIN = 2;
    localparam int RATIO_MAX = 8;

    typedef enum logic [1:0] {
        CELL_ODDR        = 2'd0,
        CELL_ODDR_SERDES = 2'd1,
        CELL_ISERDES     = 2'd2
    } cell_kind_e;

    localparam cell_kind_e CELL_KIND = CELL_ODDR_SERDES;

    function automatic int pairs(input int ratio);
        return ratio / 2;
    endfunction

    // REM counts down from PAIRS to 0, so it needs PAIRS+1 states
    function automatic int rem_width(input int ratio);
        return $clog2(ratio / 2 + 1);
    endfunction

endpackage

// File: rtl/oddr_serdes_if.sv
// rtl/oddr_serdes_if.sv - parallel word load handshake between fabric and oddr_serdes
interface oddr_serdes_if #(
    parameter int W = 4
);
    logic [W-1:0] D;
    logic         D_VALID;
    logic         D_READY;

    modport master (output D, output D_VALID, input D_READY);
    modport slave  (input D, input D_VALID, output D_READY);
endinterface

// File: rtl/oddr_serdes_lane.sv
// rtl/oddr_serdes_lane.sv - one-lane DDR output stage, Q encoded as rise XOR fall flop
module oddr_serdes_lane #(
    parameter logic SRVAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pair,
    output logic       q
);
    logic rise_q;
    logic stage_d2;
    logic fall_q;

    // Each flop stores its target bit pre-XORed with the other flop, so q
    // switches cleanly on whichever edge last updated it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_q   <= SRVAL ^ fall_q;
            stage_d2 <= SRVAL;
        end else begin
            rise_q   <= pair[0] ^ fall_q;
            stage_d2 <= pair[1];
        end
    end

    always_ff @(negedge clk) begin
        fall_q <= stage_d2 ^ rise_q;
    end

    assign q = rise_q ^ fall_q;

endmodule

// File: rtl/oddr_serdes.sv
// rtl/oddr_serdes.sv - multi-lane RATIO:1 DDR output serializer; optional ODDR_SERDES_FORCE_EN
module oddr_serdes
    import oddr_serdes_pkg::*;
#(
    parameter int   LANES         = 1,
    parameter int   RATIO         = 4,
    parameter logic IS_C_INVERTED = 1'b0,
    parameter logic SRVAL         = 1'b0
) (
    input  logic             C,
    input  logic             RST_N,
    oddr_serdes_if.slave     bus,
    output logic             BUSY,
    output logic [LANES-1:0] Q
`ifdef ODDR_SERDES_FORCE_EN
    ,
    input  logic             FORCE,
    input  logic [LANES-1:0] FORCE_VAL
`endif
);
    localparam int W     = LANES * RATIO;
    localparam int PAIRS = pairs(RATIO);
    localparam int REM_W = rem_width(RATIO);
    localparam logic [REM_W-1:0] REM_FULL = REM_W'(PAIRS);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    if ((RATIO % 2) != 0 || RATIO < RATIO_MIN || RATIO > RATIO_MAX) begin : g_bad_ratio
        $error("oddr_serdes: RATIO must be even and within 2..8");
    end
    if (LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_lanes
        $error("oddr_serdes: LANES must be within 1..16");
    end

    logic             clk;
    logic [REM_W-1:0] rem;
    logic [W-1:0]     sreg;
    logic [W-1:0]     sreg_shift;
    logic             frozen;
    logic             ready;
    logic             fire;
    logic             has_pair;
    logic [1:0]       pair_sel [LANES];

    assign clk = C ^ IS_C_INVERTED;

`ifdef ODDR_SERDES_FORCE_EN
    assign frozen = FORCE;
`else
    assign frozen = 1'b0;
`endif

    // Ready opens on the last pair so a new word can follow without a gap
    assign ready       = RST_N && (rem <= REM_ONE) && !frozen;
    assign bus.D_READY = ready;
    assign fire        = bus.D_VALID && ready;
    assign has_pair    = (rem != '0);

    always_comb begin
        logic [RATIO-1:0] lane_word;
        sreg_shift = '0;
        lane_word  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_word                     = sreg[l*RATIO +: RATIO];
            sreg_shift[l*RATIO +: RATIO] = lane_word >> 2;
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pair_sel[l] = {SRVAL, SRVAL};
`ifdef ODDR_SERDES_FORCE_EN
            if (FORCE) begin
                pair_sel[l] = {FORCE_VAL[l], FORCE_VAL[l]};
            end else
`endif
            if (has_pair) begin
                pair_sel[l] = sreg[l*RATIO +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            rem  <= '0;
            sreg <= '0;
            BUSY <= 1'b0;
        end else begin
            BUSY <= has_pair && !frozen;
            if (fire) begin
                sreg <= bus.D;
                rem  <= REM_FULL;
            end else if (has_pair && !frozen) begin
                sreg <= sreg_shift;
                rem  <= rem - REM_ONE;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        oddr_serdes_lane #(
            .SRVAL (SRVAL)
        ) u_lane (
            .clk   (clk),
            .rst_n (RST_N),
            .pair  (pair_sel[l]),
            .q     (Q[l])
        );
    end

endmodule

// File: tb/tb_oddr_serdes.sv
// tb/tb_oddr_serdes.sv - scoreboard bench for oddr_serdes, LANES=2 RATIO=4 SRVAL=1
module tb_oddr_serdes;

    logic       C = 1'b0;
    logic       RST_N = 1'b0;
    logic       BUSY;
    logic [1:0] Q;
`ifdef ODDR_SERDES_FORCE_EN
    logic       FORCE = 1'b0;
    logic [1:0] FORCE_VAL = 2'b00;
`endif

    oddr_serdes_if #(.W(8)) bus ();

    oddr_serdes #(
        .LANES         (2),
        .RATIO         (4),
        .IS_C_INVERTED (1'b0),
        .SRVAL         (1'b1)
    ) dut (
        .C     (C),
        .RST_N (RST_N),
        .bus   (bus),
        .BUSY  (BUSY),
        .Q     (Q)
`ifdef ODDR_SERDES_FORCE_EN
        ,
        .FORCE     (FORCE),
        .FORCE_VAL (FORCE_VAL)
`endif
    );

    always #5 C = ~C;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_q[$];
    logic [1:0] idle_val = 2'b11;
    bit         mon_en = 1'b0;
    int         run_len = 0;
    int         last_run = 0;
    int         w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge C);
        #1;
    endtask

    // exp8 packs the Q value of each half-phase, {q3,q2,q1,q0}; q0 is the first high phase
    task automatic push_word(input logic [7:0] exp8, input int np);
        for (int i = 0; i < np; i++) begin
            exp_q.push_back({exp8[4*i+2 +: 2], exp8[4*i +: 2]});
        end
    endtask

    task automatic send_word(input logic [7:0] d, input logic [7:0] exp8, input int np,
                             output int waited);
        bus.D       = d;
        bus.D_VALID = 1'b1;
        waited      = 0;
        while (!bus.D_READY && waited < 20) begin
            cyc();
            waited++;
        end
        if (waited >= 20) chk("ready_timeout", bus.D_READY, 1);
        push_word(exp8, np);
        cyc();
    endtask

    initial begin : monitor
        logic [1:0] qh;
        logic [1:0] ql;
        logic [1:0] iv;
        logic       b;
        logic [3:0] e;
        forever begin
            @(posedge C);
            #2;
            if (mon_en) begin
                qh = Q;
                b  = BUSY;
                iv = idle_val;
                @(negedge C);
                #2;
                ql = Q;
                if (b) begin
                    run_len++;
                    if (exp_q.size() == 0) begin
                        chk("busy_without_expected_pair", b, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("q_high_phase", qh, e[1:0]);
                        chk("q_low_phase", ql, e[3:2]);
                    end
                end else begin
                    if (run_len != 0) last_run = run_len;
                    run_len = 0;
                    chk("idle_high_phase", qh, iv);
                    chk("idle_low_phase", ql, iv);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.D       = 8'h00;
        bus.D_VALID = 1'b0;
        RST_N       = 1'b0;
        cyc();
        mon_en = 1'b1;
        repeat (2) begin
            chk("reset_ready", bus.D_READY, 0);
            chk("reset_busy", BUSY, 0);
            cyc();
        end
        RST_N = 1'b1;
        #1;
        chk("ready_after_release", bus.D_READY, 1);
        cyc();

        // single word: lane0=0101, lane1=1010
        send_word(8'hA5, 8'h99, 2, w);
        bus.D_VALID = 1'b0;
        chk("single_wait", w, 0);
        repeat (4) cyc();
        chk("single_busy_run", last_run, 2);

        // back-to-back with D_VALID held
        send_word(8'h0F, 8'h55, 2, w);
        send_word(8'hF0, 8'hAA, 2, w);
        chk("b2b_second_wait", w, 1);
        bus.D_VALID = 1'b0;
        repeat (5) cyc();
        chk("b2b_gapless_run", last_run, 4);

        // backpressure while REM=2
        send_word(8'hA5, 8'h99, 2, w);
        chk("bp_ready_low", bus.D_READY, 0);
        send_word(8'h0F, 8'h55, 2, w);
        chk("bp_wait", w, 1);
        bus.D_VALID = 1'b0;
        repeat (5) cyc();
        chk("bp_gapless_run", last_run, 4);

        // mid-word reset: only the first pair of 8'hFF ever appears
        send_word(8'hFF, 8'hFF, 1, w);
        bus.D_VALID = 1'b0;
        cyc();
        RST_N = 1'b0;
        cyc();
        chk("midrst_busy", BUSY, 0);
        chk("midrst_ready", bus.D_READY, 0);
        RST_N = 1'b1;
        #1;
        chk("midrst_ready_release", bus.D_READY, 1);
        repeat (4) cyc();
        chk("midrst_run", last_run, 1);
        send_word(8'hA5, 8'h99, 2, w);
        bus.D_VALID = 1'b0;
        repeat (4) cyc();
        chk("post_reset_run", last_run, 2);

`ifdef ODDR_SERDES_FORCE_EN
        send_word(8'hA5, 8'h99, 2, w);
        bus.D_VALID = 1'b0;
        cyc();
        FORCE     = 1'b1;
        FORCE_VAL = 2'b10;
        idle_val  = 2'b10;
        repeat (3) begin
            chk("force_ready", bus.D_READY, 0);
            cyc();
            chk("force_busy", BUSY, 0);
        end
        FORCE = 1'b0;
        cyc();
        idle_val = 2'b11;
        repeat (4) cyc();
        chk("force_resume_run", last_run, 1);
`endif

        repeat (3) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
